// File: rtl/snake_head_mover_pkg.sv
// Shared definitions for the snake head mover and the navigation FSM that
// feeds it.
//   - DIR_* : 2-bit direction codes carried on DIRECTION / DIR_APPLIED
//   - state_e : mover state machine encoding (IDLE / RUN / DEAD)
//   - is_opposite : true when two direction codes point 180 degrees apart
package snake_head_mover_pkg;

   localparam logic [1:0] DIR_RIGHT = 2'b00;
   localparam logic [1:0] DIR_DOWN  = 2'b01;
   localparam logic [1:0] DIR_UP    = 2'b10;
   localparam logic [1:0] DIR_LEFT  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_e;

   // The codes are chosen so that opposite directions are bitwise
   // complements of each other (00<->11, 01<->10).
   function automatic logic is_opposite(input logic [1:0] a, input logic [1:0] b);
      return (a ^ b) == 2'b11;
   endfunction

endpackage

// File: rtl/snake_head_mover_tick_divider.sv
// game_tick_divider: single-cycle pulse generator dividing CLOCK by TICK_DIV.
//   CLOCK  : system clock
//   RESET  : synchronous active-high reset, clears the count
//   ENABLE : count advances only while high; the count holds while low
//   TICK   : high for the one cycle in which the count sits at TICK_DIV-1
//            with ENABLE high; the count wraps to 0 on that same edge
module game_tick_divider #(
   parameter int TICK_DIV = 5000000
) (
   input  logic CLOCK,
   input  logic RESET,
   input  logic ENABLE,
   output logic TICK
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // TICK is decoded from the registered count so the consumer can act on
   // the same edge at which the count wraps.
   assign TICK = ENABLE && (count_q == CNT_LAST);

   always_comb begin
      count_d = count_q;
      if (ENABLE) begin
         if (count_q == CNT_LAST) begin
            count_d = '0;
         end else begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/snake_head_mover.sv
// snake_head_mover: advances the snake head one grid cell per game step.
//   CLOCK       : system clock
//   RESET       : synchronous active-high reset (overrides every state)
//   ENABLE      : run/pause; game steps only count down while high
//   DIRECTION   : requested direction, sampled only on the step edge
//   HEAD_X/Y    : registered head position on the GRID_W x GRID_H field
//   DIR_APPLIED : direction used by the most recent step
//   MOVE_STROBE : one-cycle pulse in the cycle the head position changed
//   GAME_OVER   : sticky wall-hit flag (never set when WRAP=1)
module snake_head_mover
   import snake_head_mover_pkg::*;
#(
   parameter int GRID_W   = 32,
   parameter int GRID_H   = 24,
   parameter int X_W      = 5,
   parameter int Y_W      = 5,
   parameter int TICK_DIV = 5000000,
   parameter int WRAP     = 0
) (
   input  logic           CLOCK,
   input  logic           RESET,
   input  logic           ENABLE,
   input  logic [1:0]     DIRECTION,
   output logic [X_W-1:0] HEAD_X,
   output logic [Y_W-1:0] HEAD_Y,
   output logic [1:0]     DIR_APPLIED,
   output logic           MOVE_STROBE,
   output logic           GAME_OVER
);

   localparam logic [X_W-1:0] X_START = X_W'(GRID_W / 2);
   localparam logic [Y_W-1:0] Y_START = Y_W'(GRID_H / 2);
   localparam logic [X_W-1:0] X_LAST  = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] Y_LAST  = Y_W'(GRID_H - 1);
   localparam bit             WRAP_EN = (WRAP != 0);

   state_e         state_q, state_d;
   logic [X_W-1:0] head_x_q, head_x_d;
   logic [Y_W-1:0] head_y_q, head_y_d;
   logic [1:0]     dir_q, dir_d;
   logic           strobe_q, strobe_d;
   logic           game_over_q, game_over_d;

   logic           step_tick;
   logic [1:0]     dir_sel;
   logic [X_W-1:0] next_x;
   logic [Y_W-1:0] next_y;
   logic           edge_hit;

   // Counting only happens in RUN, so the count stays 0 in IDLE and freezes
   // in DEAD.
   game_tick_divider #(
      .TICK_DIV(TICK_DIV)
   ) u_tick (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .ENABLE(ENABLE && (state_q == ST_RUN)),
      .TICK  (step_tick)
   );

   // Candidate move. The edge test is made on the current coordinate before
   // any add/sub, so an unsigned underflow never occurs and GRID_W/GRID_H
   // need not be powers of two. next_* already holds the wrapped cell.
   always_comb begin
      dir_sel  = is_opposite(DIRECTION, dir_q) ? dir_q : DIRECTION;
      next_x   = head_x_q;
      next_y   = head_y_q;
      edge_hit = 1'b0;
      case (dir_sel)
         DIR_RIGHT: begin
            if (head_x_q == X_LAST) begin
               edge_hit = 1'b1;
               next_x   = '0;
            end else begin
               next_x = head_x_q + X_W'(1);
            end
         end
         DIR_LEFT: begin
            if (head_x_q == '0) begin
               edge_hit = 1'b1;
               next_x   = X_LAST;
            end else begin
               next_x = head_x_q - X_W'(1);
            end
         end
         DIR_DOWN: begin
            if (head_y_q == Y_LAST) begin
               edge_hit = 1'b1;
               next_y   = '0;
            end else begin
               next_y = head_y_q + Y_W'(1);
            end
         end
         default: begin // DIR_UP
            if (head_y_q == '0) begin
               edge_hit = 1'b1;
               next_y   = Y_LAST;
            end else begin
               next_y = head_y_q - Y_W'(1);
            end
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      head_x_d    = head_x_q;
      head_y_d    = head_y_q;
      dir_d       = dir_q;
      strobe_d    = 1'b0;
      game_over_d = game_over_q;
      case (state_q)
         ST_IDLE: begin
            if (ENABLE) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (step_tick) begin
               // A fatal step still records the direction that was attempted.
               dir_d = dir_sel;
               if (edge_hit && !WRAP_EN) begin
                  state_d     = ST_DEAD;
                  game_over_d = 1'b1;
               end else begin
                  head_x_d = next_x;
                  head_y_d = next_y;
                  strobe_d = 1'b1;
               end
            end
         end
         ST_DEAD: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCK) begin
      if (RESET) begin
         state_q     <= ST_IDLE;
         head_x_q    <= X_START;
         head_y_q    <= Y_START;
         dir_q       <= DIR_RIGHT;
         strobe_q    <= 1'b0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         head_x_q    <= head_x_d;
         head_y_q    <= head_y_d;
         dir_q       <= dir_d;
         strobe_q    <= strobe_d;
         game_over_q <= game_over_d;
      end
   end

   assign HEAD_X      = head_x_q;
   assign HEAD_Y      = head_y_q;
   assign DIR_APPLIED = dir_q;
   assign MOVE_STROBE = strobe_q;
   assign GAME_OVER   = game_over_q;

endmodule

// File: tb/tb_snake_head_mover.sv
// Bench for snake_head_mover: one wall-terminating instance (WRAP=0) and one
// wrapping instance (WRAP=1) share the same stimulus. A behavioural model of
// each is compared against the DUT outputs every cycle; directed phases add
// hand-computed literal expectations.
module tb_snake_head_mover;

   localparam int TD = 4;
   localparam int GW = 8;
   localparam int GH = 6;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [1:0] dir_in = 2'b00;

   logic [2:0] hx0, hy0, hx1, hy1;
   logic [1:0] da0, da1;
   logic       ms0, ms1, go0, go1;

   int checks = 0;
   int failures = 0;

   // model state, index 0 = WRAP=0 instance, 1 = WRAP=1 instance
   int m_x[2], m_y[2], m_dir[2], m_cnt[2];
   bit m_run[2], m_dead[2], m_ms[2], m_go[2];

   always #5 clk = ~clk;

   snake_head_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3),
                      .TICK_DIV(TD), .WRAP(0)) dut_wall (
      .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir_in),
      .HEAD_X(hx0), .HEAD_Y(hy0), .DIR_APPLIED(da0),
      .MOVE_STROBE(ms0), .GAME_OVER(go0)
   );

   snake_head_mover #(.GRID_W(GW), .GRID_H(GH), .X_W(3), .Y_W(3),
                      .TICK_DIV(TD), .WRAP(1)) dut_wrap (
      .CLOCK(clk), .RESET(rst), .ENABLE(en), .DIRECTION(dir_in),
      .HEAD_X(hx1), .HEAD_Y(hy1), .DIR_APPLIED(da1),
      .MOVE_STROBE(ms1), .GAME_OVER(go1)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // One game step in plain integer arithmetic.
   task automatic model_step(input int w);
      int d, nx, ny;
      d = int'(dir_in);
      if (d == 3 - m_dir[w]) d = m_dir[w];   // 180-degree turn is ignored
      nx = m_x[w] + ((d == 0) ? 1 : 0) - ((d == 3) ? 1 : 0);
      ny = m_y[w] + ((d == 1) ? 1 : 0) - ((d == 2) ? 1 : 0);
      m_dir[w] = d;
      if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
         if (w == 0) begin
            m_dead[w] = 1'b1;
            m_go[w]   = 1'b1;
            return;
         end
         nx = (nx + GW) % GW;
         ny = (ny + GH) % GH;
      end
      m_x[w]  = nx;
      m_y[w]  = ny;
      m_ms[w] = 1'b1;
   endtask

   task automatic model_edge(input int w);
      if (rst) begin
         m_x[w] = GW / 2; m_y[w] = GH / 2; m_dir[w] = 0; m_cnt[w] = 0;
         m_run[w] = 1'b0; m_dead[w] = 1'b0; m_ms[w] = 1'b0; m_go[w] = 1'b0;
      end else begin
         m_ms[w] = 1'b0;
         if (m_dead[w]) begin
         end else if (!m_run[w]) begin
            if (en) m_run[w] = 1'b1;
         end else if (en) begin
            if (m_cnt[w] == TD - 1) begin
               m_cnt[w] = 0;
               model_step(w);
            end else begin
               m_cnt[w]++;
            end
         end
      end
   endtask

   // Per-cycle compare, 1 time unit after the active edge.
   always begin
      @(posedge clk);
      for (int w = 0; w < 2; w++) model_edge(w);
      #1;
      check("wall.head_x", int'(hx0), m_x[0]);
      check("wall.head_y", int'(hy0), m_y[0]);
      check("wall.dir_applied", int'(da0), m_dir[0]);
      check("wall.move_strobe", int'(ms0), int'(m_ms[0]));
      check("wall.game_over", int'(go0), int'(m_go[0]));
      check("wrap.head_x", int'(hx1), m_x[1]);
      check("wrap.head_y", int'(hy1), m_y[1]);
      check("wrap.dir_applied", int'(da1), m_dir[1]);
      check("wrap.move_strobe", int'(ms1), int'(m_ms[1]));
      check("wrap.game_over", int'(go1), int'(m_go[1]));
   end

   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   initial begin
      // reset state
      edges(2);
      rst = 1'b0;
      $display("phase reset: head=(%0d,%0d)", hx0, hy0);
      check("lit.reset_x", int'(hx0), 4);
      check("lit.reset_y", int'(hy0), 3);
      check("lit.reset_dir", int'(da0), 0);
      check("lit.reset_strobe", int'(ms0), 0);
      check("lit.reset_go", int'(go0), 0);

      // run right toward the east wall
      en = 1'b1;
      edges(5);
      $display("step 1: head=(%0d,%0d) strobe=%0d", hx0, hy0, ms0);
      check("lit.step1_strobe", int'(ms0), 1);
      check("lit.step1_x", int'(hx0), 5);
      edges(1);
      check("lit.strobe_one_cycle", int'(ms0), 0);
      edges(3);
      check("lit.step2_x", int'(hx0), 6);
      edges(4);
      check("lit.step3_x", int'(hx0), 7);
      check("lit.step3_y", int'(hy0), 3);
      edges(4);
      $display("wall step: wall=(%0d,%0d) go=%0d wrap=(%0d,%0d)", hx0, hy0, go0, hx1, hy1);
      check("lit.wall_strobe", int'(ms0), 0);
      check("lit.wall_go", int'(go0), 1);
      check("lit.wall_x", int'(hx0), 7);
      check("lit.wrap_x", int'(hx1), 0);
      check("lit.wrap_strobe", int'(ms1), 1);

      // turn up; dead instance ignores it, wrap instance climbs past row 0
      dir_in = 2'b10;
      edges(12);
      check("lit.dead_frozen_y", int'(hy0), 3);
      check("lit.dead_dir", int'(da0), 0);
      check("lit.wrap_at_00_y", int'(hy1), 0);
      edges(4);
      $display("wrap up: head=(%0d,%0d)", hx1, hy1);
      check("lit.wrap_up_x", int'(hx1), 0);
      check("lit.wrap_up_y", int'(hy1), 5);
      check("lit.wrap_go", int'(go1), 0);

      // reset revives; reversal rejection
      rst = 1'b1;
      edges(1);
      check("lit.rst_x", int'(hx0), 4);
      check("lit.rst_go", int'(go0), 0);
      rst = 1'b0;
      dir_in = 2'b00;
      edges(5);
      check("lit.rev_pre_x", int'(hx0), 5);
      dir_in = 2'b11;
      edges(4);
      $display("reversal: head=(%0d,%0d) dir=%0d", hx0, hy0, da0);
      check("lit.rev_x", int'(hx0), 6);
      check("lit.rev_dir", int'(da0), 0);
      dir_in = 2'b01;
      edges(4);
      check("lit.down_y", int'(hy0), 4);
      check("lit.down_dir", int'(da0), 1);

      // pause 2 cycles into a step for 10 cycles
      edges(2);
      en = 1'b0;
      edges(10);
      check("lit.pause_y", int'(hy0), 4);
      en = 1'b1;
      edges(1);
      check("lit.resume_no_strobe", int'(ms0), 0);
      edges(1);
      $display("resume: head=(%0d,%0d) strobe=%0d", hx0, hy0, ms0);
      check("lit.resume_strobe", int'(ms0), 1);
      check("lit.resume_y", int'(hy0), 5);

      // reset lands on the edge where a step would fire
      edges(3);
      rst = 1'b1;
      edges(1);
      check("lit.rst_step_x", int'(hx1), 4);
      check("lit.rst_step_y", int'(hy1), 3);
      check("lit.rst_step_strobe", int'(ms1), 0);
      rst = 1'b0;

      // randomized phase, checked by the per-cycle model
      for (int i = 0; i < 4000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         en     = ($urandom_range(0, 9) != 0);
         dir_in = 2'($urandom_range(0, 3));
         edges(1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/snake_head_mover.md
Name: snake_head_mover

Overview:
- Downstream consumer of the navigation FSM's 2-bit direction output (00 right, 01 down, 10 up, 11 left).
- Divides CLOCK into a game-step tick. On each tick it samples the direction, rejects 180° reversals, and advances the snake head one cell on the playfield grid.
- Detects wall hits (or wraps around, per parameter) and drives a sticky game-over flag to the renderer and body-tracking logic.

Parameters:
- GRID_W, 32, playfield width in cells (>=2)
- GRID_H, 24, playfield height in cells (>=2)
- X_W, 5, HEAD_X width; must satisfy 2**X_W >= GRID_W
- Y_W, 5, HEAD_Y width; must satisfy 2**Y_W >= GRID_H
- TICK_DIV, 5000000, CLOCK cycles per game step (>=2)
- WRAP, 0, 0 = wall hit ends game; 1 = head wraps to opposite edge

Ports:
- CLOCK  input  1  system clock; single clock domain
- RESET  input  1  synchronous, active-high reset
- ENABLE  input  1  run/pause; step counter advances only while high
- DIRECTION  input  2  requested direction from navigation FSM
- HEAD_X  output  X_W  current head column, 0..GRID_W-1
- HEAD_Y  output  Y_W  current head row, 0..GRID_H-1
- DIR_APPLIED  output  2  direction used for the last move
- MOVE_STROBE  output  1  one-cycle pulse in the cycle the head registers update
- GAME_OVER  output  1  sticky; high once a wall hit occurs

Behaviour:
- All outputs are registered. Everything is clocked on posedge CLOCK.
- Reset (RESET high at a clock edge; overrides everything, including mid-step or DEAD):
  - state=IDLE, tick counter=0
  - HEAD_X=GRID_W/2, HEAD_Y=GRID_H/2 (integer division)
  - DIR_APPLIED=00, MOVE_STROBE=0, GAME_OVER=0
- States:
  - IDLE: waits for ENABLE=1, then goes to RUN. The counter stays 0.
  - RUN, ENABLE=1: the counter increments. When counter==TICK_DIV-1 it returns to 0 and a step executes in that same edge.
  - RUN, ENABLE=0: paused. The counter holds and no step occurs. Resumes counting when ENABLE returns to 1; state remains RUN.
  - DEAD: entered on a wall hit. Head, DIR_APPLIED and counter freeze. GAME_OVER=1. MOVE_STROBE=0. Only RESET exits.
- Step timing: the first step occurs exactly TICK_DIV cycles after the first RUN cycle with ENABLE=1.
- Step execution:
  - Sample DIRECTION into cand.
  - If cand is the opposite of DIR_APPLIED (00<->11, 01<->10), use dir=DIR_APPLIED. Otherwise use dir=cand. This covers two FSM turns landing inside one tick.
  - Deltas: right x+1, left x-1, down y+1, up y-1.
- Boundaries:
  - WRAP=0, move would leave the grid (x==GRID_W-1 right, x==0 left, y==GRID_H-1 down, y==0 up):
    - head unchanged
    - DIR_APPLIED updated to dir
    - GAME_OVER=1, state=DEAD
    - MOVE_STROBE=0 for that step
  - WRAP=1: x wraps GRID_W-1<->0 and y wraps GRID_H-1<->0. Never goes DEAD.
  - Arithmetic: out-of-range compare is done before add/sub, so no underflow occurs. GRID_W is not required to be a power of two.
- Successful step: HEAD_X/HEAD_Y and DIR_APPLIED update, and MOVE_STROBE=1 for exactly that cycle.
- DIRECTION is sampled only on the step edge. Changes between ticks have no effect.
- Latency: DIRECTION sampled at step edge N appears on the outputs after edge N.

Decomposition:
- Shared package/header holds:
  - direction constants DIR_RIGHT=2'b00, DIR_DOWN=2'b01, DIR_UP=2'b10, DIR_LEFT=2'b11 (the navigation FSM also uses these)
  - state encodings IDLE/RUN/DEAD
  - an is_opposite function
- Natural sub-module: game_tick_divider. Parameter TICK_DIV; inputs CLOCK, RESET, ENABLE; output TICK. A reusable single-cycle pulse generator that holds its count while ENABLE is low.

Test Plan (TICK_DIV=4, GRID 8x6, X_W=3, Y_W=3 unless stated):
- Reset, then ENABLE=1 with DIRECTION=00: HEAD starts at (4,3). MOVE_STROBE pulses every 4 cycles. HEAD goes to (5,3), then (6,3), then (7,3).
- Continue right from (7,3) with WRAP=0: no MOVE_STROBE, GAME_OVER=1, HEAD stays (7,3). Further ticks and DIRECTION changes have no effect until RESET, which restores (4,3) and GAME_OVER=0.
- Same stimulus with WRAP=1: from (7,3) the next step goes to (0,3). Moving up from (0,0) goes to (0,5). GAME_OVER stays 0.
- DIR_APPLIED=00, DIRECTION=11 at the tick: reversal is rejected and the head moves right. DIRECTION=01 at the next tick: the head moves down (y+1) and DIR_APPLIED=01.
- ENABLE dropped 2 cycles into a step for 10 cycles: no movement while low. The step completes 2 cycles after ENABLE is restored.
- RESET asserted in the cycle a step would fire: reset wins, HEAD=(4,3), MOVE_STROBE=0, counter=0.
